radial_ring_generator: RTL and testbench

- Parametrised concentric-ring pattern source for the VGA pattern mux. Takes the current beam position (x, y) and produces a 6-bit RRGGBB colour.
- Ring centre, ring pitch, ring count, distance metric and animation mode are configurable.
- Adds ping-pong (grow/shrink) animation, frame-aligned mode latching and a registered pixel output.

---
 rtl/radial_ring_generator.sv | 168 ++++++++++++++++
 tb/tb_radial_ring_generator.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radial_ring_generator.sv
// radial_ring_generator: concentric-ring RRGGBB source keyed on beam (x, y), rings animated once per frame.
// Latency: 1 cycle from (x, y) to the registered rgb/ring_idx.
// Backpressure: none; free-running pixel path that accepts a new pixel every cycle.
// Optional: define RADIAL_RING_PALETTE_ROTATE_EN to rotate ring colours by one entry every 16 frames.
module radial_ring_generator #(
  parameter int CW        = 10,
  parameter int CX        = 320,
  parameter int CY        = 240,
  parameter int RING_STEP = 24,
  parameter int NUM_RINGS = 5,
  parameter int FC_W      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          next_frame,
  input  logic [2:0]    step_size,
  input  logic [1:0]    metric_sel,
  input  logic          anim_mode,
  output logic [5:0]    rgb,
  output logic [3:0]    ring_idx
);

  typedef enum logic {ST_GROW = 1'b0, ST_SHRINK = 1'b1} state_t;

  localparam logic [FC_W-1:0] FC_MAX   = {FC_W{1'b1}};
  localparam logic [CW:0]     CXV      = (CW+1)'(CX);
  localparam logic [CW:0]     CYV      = (CW+1)'(CY);
  localparam logic [5:0]      EDGE_RGB = 6'b000001;

  state_t          r_state, w_state_nxt;
  logic [FC_W-1:0] r_fc, w_fc_nxt;
  logic [1:0]      r_metric;
  logic            r_anim;
  logic [FC_W-1:0] w_step;
  logic [FC_W:0]   w_fc_sum;
  logic [CW:0]     w_x, w_y, w_dx, w_dy, w_max, w_min, w_dist;
  logic [CW+1:0]   w_base;
  logic [3:0]      w_ring;
  logic [2:0]      w_pidx;

  assign w_step   = FC_W'(step_size);
  assign w_fc_sum = {1'b0, r_fc} + {1'b0, w_step};

  // Mode controls only change at frame boundaries so a frame never mixes metrics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_metric <= 2'd0;
      r_anim   <= 1'b0;
    end else if (next_frame) begin
      r_metric <= metric_sel;
      r_anim   <= anim_mode;
    end
  end

  // Animation counter and ping-pong direction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_GROW;
      r_fc    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fc    <= w_fc_nxt;
    end
  end

  // Next counter value; expand mode wraps, ping-pong saturates and turns around
  always_comb begin
    w_fc_nxt    = r_fc;
    w_state_nxt = r_state;
    // Expand mode has no direction, so park the FSM in GROW for a later switch back
    if (!r_anim) w_state_nxt = ST_GROW;
    if (next_frame && (step_size != 3'd0)) begin
      if (!r_anim) begin
        w_fc_nxt = w_fc_sum[FC_W-1:0];
      end else if (r_state == ST_GROW) begin
        if (w_fc_sum >= {1'b0, FC_MAX}) begin
          w_fc_nxt    = FC_MAX;
          w_state_nxt = ST_SHRINK;
        end else begin
          w_fc_nxt = w_fc_sum[FC_W-1:0];
        end
      end else begin
        if (r_fc <= w_step) begin
          w_fc_nxt    = '0;
          w_state_nxt = ST_GROW;
        end else begin
          w_fc_nxt = r_fc - w_step;
        end
      end
    end
  end

  assign w_x   = {1'b0, x};
  assign w_y   = {1'b0, y};
  assign w_dx  = (w_x >= CXV) ? (w_x - CXV) : (CXV - w_x);
  assign w_dy  = (w_y >= CYV) ? (w_y - CYV) : (CYV - w_y);
  assign w_max = (w_dx >= w_dy) ? w_dx : w_dy;
  assign w_min = (w_dx >= w_dy) ? w_dy : w_dx;

  // Distance from ring centre under the latched metric; code 3 falls back to manhattan
  always_comb begin
    case (r_metric)
      2'd1:    w_dist = w_max;
      2'd2:    w_dist = w_max + (w_min >> 1);
      default: w_dist = w_dx + w_dy;
    endcase
  end

  assign w_base = (CW+2)'(r_fc >> 3);

  // Innermost ring whose threshold covers the pixel; descending scan lets the smallest k win
  always_comb begin
    w_ring = 4'(NUM_RINGS);
    for (int k = NUM_RINGS - 1; k >= 0; k--) begin
      if ({1'b0, w_dist} <= (w_base + (CW+2)'((k + 1) * RING_STEP))) w_ring = 4'(k);
    end
  end

  function automatic logic [5:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 6'b101101;
      3'd1:    palette = 6'b101100;
      3'd2:    palette = 6'b101000;
      3'd3:    palette = 6'b001100;
      3'd4:    palette = 6'b001000;
      3'd5:    palette = 6'b000100;
      3'd6:    palette = 6'b000110;
      default: palette = 6'b000010;
    endcase
  endfunction

`ifdef RADIAL_RING_PALETTE_ROTATE_EN
  logic [3:0] r_div;
  logic [2:0] r_off;
  logic [3:0] w_pidx_sum;

  // Advance the palette offset once every 16 frames, wrapping at NUM_RINGS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= 4'd0;
      r_off <= 3'd0;
    end else if (next_frame) begin
      r_div <= r_div + 4'd1;
      if (r_div == 4'hF) r_off <= (r_off == 3'(NUM_RINGS - 1)) ? 3'd0 : (r_off + 3'd1);
    end
  end

  assign w_pidx_sum = w_ring + {1'b0, r_off};
  assign w_pidx     = (w_pidx_sum >= 4'(NUM_RINGS)) ? 3'(w_pidx_sum - 4'(NUM_RINGS))
                                                     : w_pidx_sum[2:0];
`else
  assign w_pidx = w_ring[2:0];
`endif

  // Registered pixel output; edge colour never rotates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb      <= EDGE_RGB;
      ring_idx <= 4'(NUM_RINGS);
    end else begin
      ring_idx <= w_ring;
      rgb      <= (w_ring >= 4'(NUM_RINGS)) ? EDGE_RGB : palette(w_pidx);
    end
  end

endmodule

// File: tb/tb_radial_ring_generator.sv
// tb_radial_ring_generator: self-checking bench for radial_ring_generator.
// Latency: outputs sampled 1 ns after the edge that registers the pixel.
// Backpressure: n/a; stimulus is one pixel per clock.
module tb_radial_ring_generator;
  localparam int CW     = 10;
  localparam int CX     = 320;
  localparam int CY     = 240;
  localparam int RS     = 24;
  localparam int NR     = 5;
  localparam int FC_W   = 10;
  localparam int FC_MOD = 1 << FC_W;
  localparam logic [5:0] PAL [8] = '{6'b101101, 6'b101100, 6'b101000, 6'b001100,
                                     6'b001000, 6'b000100, 6'b000110, 6'b000010};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] x = '0;
  logic [CW-1:0] y = '0;
  logic          next_frame = 1'b0;
  logic [2:0]    step_size = 3'd0;
  logic [1:0]    metric_sel = 2'd0;
  logic          anim_mode = 1'b0;
  logic [5:0]    rgb;
  logic [3:0]    ring_idx;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_fc, m_met, m_anim, m_pulses;
  bit m_grow;

  radial_ring_generator #(
    .CW(CW), .CX(CX), .CY(CY), .RING_STEP(RS), .NUM_RINGS(NR), .FC_W(FC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .next_frame(next_frame),
    .step_size(step_size), .metric_sel(metric_sel), .anim_mode(anim_mode),
    .rgb(rgb), .ring_idx(ring_idx)
  );

  always #5 clk = ~clk;

  function automatic int model_ring(input int px, input int py, input int met, input int fcv);
    int dx, dy, mx, mn, d;
    dx = (px > CX) ? px - CX : CX - px;
    dy = (py > CY) ? py - CY : CY - py;
    mx = (dx > dy) ? dx : dy;
    mn = (dx > dy) ? dy : dx;
    case (met)
      1:       d = mx;
      2:       d = mx + mn / 2;
      default: d = dx + dy;
    endcase
    for (int k = 0; k < NR; k++) begin
      if (d <= fcv / 8 + (k + 1) * RS) return k;
    end
    return NR;
  endfunction

  function automatic logic [5:0] model_rgb(input int ring, input int pulses);
    int off;
    off = 0;
`ifdef RADIAL_RING_PALETTE_ROTATE_EN
    off = (pulses / 16) % NR;
`endif
    if (ring >= NR) return 6'b000001;
    return PAL[(ring + off) % NR];
  endfunction

  task automatic model_reset();
    m_fc = 0; m_met = 0; m_anim = 0; m_pulses = 0; m_grow = 1'b1;
  endtask

  task automatic model_pulse(input int st, input int met, input int anim);
    if (m_anim == 0) begin
      m_fc = (m_fc + st) % FC_MOD;
    end else if (st != 0) begin
      if (m_grow) begin
        if (m_fc + st >= FC_MOD - 1) begin m_fc = FC_MOD - 1; m_grow = 1'b0; end
        else m_fc = m_fc + st;
      end else begin
        if (m_fc <= st) begin m_fc = 0; m_grow = 1'b1; end
        else m_fc = m_fc - st;
      end
    end
    m_met = met;
    m_anim = anim;
    if (anim == 0) m_grow = 1'b1;
    m_pulses++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next_frame = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // one clock of stimulus; outputs are valid on return
  task automatic drive_cycle(input int px, input int py, input bit nf, input int st,
                             input int met, input int anim);
    x = CW'(px); y = CW'(py);
    next_frame = nf;
    step_size = 3'(st);
    metric_sel = 2'(met);
    anim_mode = anim[0];
    @(posedge clk);
    #1;
    next_frame = 1'b0;
    if (nf) model_pulse(st, met, anim);
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (rgb !== 6'b000001) begin bad++; $display("FAIL reset_rgb: got %b want 000001", rgb); end
    total++;
    if (ring_idx !== 4'(NR)) begin bad++; $display("FAIL reset_ring: got %0d want %0d", ring_idx, NR); end
    total++;
    if (dut.r_fc !== '0) begin bad++; $display("FAIL reset_fc: got %0d want 0", dut.r_fc); end
  endtask

  task automatic test_centre_rings();
    int pts_x [4] = '{320, 344, 345, 0};
    int pts_y [4] = '{240, 240, 240, 0};
    int exp_r [4] = '{0, 0, 1, 5};
    logic [5:0] exp_c [4] = '{6'b101101, 6'b101101, 6'b101100, 6'b000001};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(pts_x[i], pts_y[i], 1'b0, 0, 0, 0);
      total++;
      if (rgb !== exp_c[i] || ring_idx !== 4'(exp_r[i])) begin
        bad++;
        $display("FAIL centre_rings[%0d]: got rgb=%b ring=%0d want rgb=%b ring=%0d",
                 i, rgb, ring_idx, exp_c[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_metric_latch();
    drive_cycle(340, 260, 1'b0, 0, 1, 0);
    total++;
    if (rgb !== 6'b101100 || ring_idx !== 4'd1) begin
      bad++; $display("FAIL metric_unlatched: got rgb=%b ring=%0d want 101100 ring 1", rgb, ring_idx);
    end
    drive_cycle(340, 260, 1'b1, 0, 1, 0);
    total++;
    if (ring_idx !== 4'd1) begin
      bad++; $display("FAIL metric_on_pulse: got ring=%0d want 1", ring_idx);
    end
    drive_cycle(340, 260, 1'b0, 0, 0, 0);
    total++;
    if (rgb !== 6'b101101 || ring_idx !== 4'd0) begin
      bad++; $display("FAIL metric_latched: got rgb=%b ring=%0d want 101101 ring 0", rgb, ring_idx);
    end
  endtask

  // pulse with a random pixel, checking both the pixel (pre-update) and the new counter
  task automatic pp_pulse(input int st, input int anim, input string tag);
    int px, py, er;
    logic [5:0] ec;
    px = $urandom_range(150, 500);
    py = $urandom_range(80, 400);
    er = model_ring(px, py, m_met, m_fc);
    ec = model_rgb(er, m_pulses);
    drive_cycle(px, py, 1'b1, st, 0, anim);
    total++;
    if (rgb !== ec || ring_idx !== 4'(er) || dut.r_fc !== FC_W'(m_fc)) begin
      bad++;
      $display("FAIL %s: got rgb=%b ring=%0d fc=%0d want rgb=%b ring=%0d fc=%0d",
               tag, rgb, ring_idx, dut.r_fc, ec, er, m_fc);
    end
  endtask

  task automatic test_pingpong();
    do_reset();
    pp_pulse(0, 1, "pp_latch");
    for (int i = 0; i < 146; i++) pp_pulse(7, 1, "pp_grow");
    total++;
    if (dut.r_fc !== 10'd1022) begin bad++; $display("FAIL pp_1022: got %0d want 1022", dut.r_fc); end
    pp_pulse(7, 1, "pp_top");
    total++;
    if (dut.r_fc !== 10'd1023) begin bad++; $display("FAIL pp_1023: got %0d want 1023", dut.r_fc); end
    pp_pulse(7, 1, "pp_turn");
    total++;
    if (dut.r_fc !== 10'd1016) begin bad++; $display("FAIL pp_1016: got %0d want 1016", dut.r_fc); end
    pp_pulse(0, 1, "pp_hold");
    total++;
    if (dut.r_fc !== 10'd1016) begin bad++; $display("FAIL pp_hold: got %0d want 1016", dut.r_fc); end
    for (int i = 0; i < 144; i++) pp_pulse(7, 1, "pp_shrink");
    pp_pulse(3, 1, "pp_to5");
    total++;
    if (dut.r_fc !== 10'd5) begin bad++; $display("FAIL pp_5: got %0d want 5", dut.r_fc); end
    pp_pulse(7, 1, "pp_floor");
    total++;
    if (dut.r_fc !== 10'd0) begin bad++; $display("FAIL pp_0: got %0d want 0", dut.r_fc); end
    pp_pulse(7, 1, "pp_regrow");
    total++;
    if (dut.r_fc !== 10'd7) begin bad++; $display("FAIL pp_regrow_7: got %0d want 7", dut.r_fc); end
  endtask

  task automatic test_expand_wrap();
    do_reset();
    for (int i = 0; i < 146; i++) pp_pulse(7, 0, "ex_grow");
    drive_cycle(348, 240, 1'b0, 0, 0, 0);
    total++;
    if (ring_idx !== 4'd0) begin bad++; $display("FAIL ex_big_radius: got ring=%0d want 0", ring_idx); end
    pp_pulse(4, 0, "ex_wrap");
    total++;
    if (dut.r_fc !== 10'd2) begin bad++; $display("FAIL ex_wrap_2: got %0d want 2", dut.r_fc); end
    drive_cycle(348, 240, 1'b0, 0, 0, 0);
    total++;
    if (ring_idx !== 4'd1 || rgb !== 6'b101100) begin
      bad++; $display("FAIL ex_base0: got rgb=%b ring=%0d want 101100 ring 1", rgb, ring_idx);
    end
  endtask

  task automatic test_random();
    int px, py, er, st, met, anim;
    bit nf;
    logic [5:0] ec;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
      end else begin
        px = $urandom_range(120, 520); py = $urandom_range(40, 440);
      end
      nf = ($urandom_range(0, 3) == 0);
      st = $urandom_range(0, 7);
      met = $urandom_range(0, 3);
      anim = $urandom_range(0, 1);
      er = model_ring(px, py, m_met, m_fc);
      ec = model_rgb(er, m_pulses);
      drive_cycle(px, py, nf, st, met, anim);
      total++;
      if (rgb !== ec || ring_idx !== 4'(er) || dut.r_fc !== FC_W'(m_fc)) begin
        bad++;
        $display("FAIL random[%0d]: got rgb=%b ring=%0d fc=%0d want rgb=%b ring=%0d fc=%0d",
                 i, rgb, ring_idx, dut.r_fc, ec, er, m_fc);
      end
    end
  endtask

  task automatic test_palette_cycle();
    int er, px;
    logic [5:0] ec;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      px = (i % 2 == 0) ? 320 : 0;
      er = model_ring(px, 240, m_met, m_fc);
      ec = model_rgb(er, m_pulses);
      drive_cycle(px, 240, 1'b1, 0, 0, 0);
      total++;
      if (rgb !== ec || ring_idx !== 4'(er)) begin
        bad++;
        $display("FAIL palette[%0d]: got rgb=%b ring=%0d want rgb=%b ring=%0d", i, rgb, ring_idx, ec, er);
      end
    end
    drive_cycle(320, 240, 1'b0, 0, 0, 0);
    total++;
    if (rgb !== 6'b101101) begin bad++; $display("FAIL palette_return: got %b want 101101", rgb); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 20; i++) pp_pulse(5, 0, "rst_prep");
    drive_cycle(320, 240, 1'b0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    total++;
    if (rgb !== 6'b000001 || ring_idx !== 4'(NR)) begin
      bad++; $display("FAIL midframe_reset_out: got rgb=%b ring=%0d want 000001 ring %0d", rgb, ring_idx, NR);
    end
    total++;
    if (dut.r_fc !== '0) begin bad++; $display("FAIL midframe_reset_fc: got %0d want 0", dut.r_fc); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    drive_cycle(348, 240, 1'b1, 1, 0, 0);
    total++;
    if (ring_idx !== 4'd1 || dut.r_fc !== 10'd1) begin
      bad++; $display("FAIL midframe_resume: got ring=%0d fc=%0d want ring 1 fc 1", ring_idx, dut.r_fc);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_centre_rings();
    test_metric_latch();
    test_pingpong();
    test_expand_wrap();
    test_random();
    test_palette_cycle();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
